semaforo_multi: RTL and testbench

Parametrised traffic-light controller for N_WAYS conflicting approaches, with a latched pedestrian request and an all-red clearance interval. It is the generalised successor of the two-way `semaforo` and uses the same `clk`/`rst`/`bt` signals and the same 3-bit per-light encoding. Ways receive green in round-robin order. A pending pedestrian request shortens the current green and inserts a walk phase in which all vehicle lights are red.

---
 rtl/semaforo_multi.sv | 139 +++++++++++++
 tb/tb_semaforo_multi.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/semaforo_multi.sv
// Round-robin traffic-light controller for N_WAYS conflicting approaches with a
// latched pedestrian request, all-red clearance and a walk phase.
module semaforo_multi #(
    parameter int N_WAYS     = 2,
    parameter int CNT_W      = 8,
    parameter int T_VERDE    = 3,
    parameter int T_AMARELO  = 3,
    parameter int T_VERMELHO = 1,
    parameter int T_PEDESTRE = 4,
    parameter int MIN_VERDE  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bt,
    output logic [3*N_WAYS-1:0]   luzes,
    output logic [2:0]            way_idx,
    output logic                  walk,
    output logic                  pend
);

    typedef enum logic [1:0] {
        VERDE          = 2'd0,
        AMARELO        = 2'd1,
        TODOS_VERMELHO = 2'd2,
        PEDESTRE       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] LAST_VERDE = CNT_W'(T_VERDE - 1);
    localparam logic [CNT_W-1:0] LAST_AMAR  = CNT_W'(T_AMARELO - 1);
    localparam logic [CNT_W-1:0] LAST_VERM  = CNT_W'(T_VERMELHO - 1);
    localparam logic [CNT_W-1:0] LAST_PED   = CNT_W'(T_PEDESTRE - 1);
    localparam logic [CNT_W-1:0] MIN_CNT    = CNT_W'(MIN_VERDE - 1);
    localparam logic [2:0]       LAST_WAY   = 3'(N_WAYS - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         way_q, way_d;
    logic               pend_q, pend_d;
    logic [2:0]         next_way_s;
    logic [3*N_WAYS-1:0] luzes_s;

    // Next-state, phase counter and pedestrian-request latch
    always_comb begin
        state_d    = state_q;
        way_d      = way_q;
        next_way_s = (way_q == LAST_WAY) ? 3'd0 : way_q + 3'd1;
        case (state_q)
            VERDE: begin
                // A latched request may cut the green short, but never below MIN_VERDE
                if ((cnt_q == LAST_VERDE) || (pend_q && (cnt_q >= MIN_CNT))) begin
                    state_d = AMARELO;
                end else begin
                    state_d = VERDE;
                end
            end
            AMARELO: begin
                if (cnt_q == LAST_AMAR) begin
                    state_d = TODOS_VERMELHO;
                end else begin
                    state_d = AMARELO;
                end
            end
            TODOS_VERMELHO: begin
                if (cnt_q == LAST_VERM) begin
                    if (pend_q) begin
                        state_d = PEDESTRE;
                    end else begin
                        state_d = VERDE;
                        way_d   = next_way_s;
                    end
                end else begin
                    state_d = TODOS_VERMELHO;
                end
            end
            PEDESTRE: begin
                if (cnt_q == LAST_PED) begin
                    state_d = VERDE;
                    way_d   = next_way_s;
                end else begin
                    state_d = PEDESTRE;
                end
            end
            default: begin
                state_d = VERDE;
                way_d   = 3'd0;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Entering the walk phase wins over a press sampled on the same edge
        if ((state_d == PEDESTRE) && (state_q != PEDESTRE)) begin
            pend_d = 1'b0;
        end else if (bt && (state_q != PEDESTRE)) begin
            pend_d = 1'b1;
        end else begin
            pend_d = pend_q;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= VERDE;
            cnt_q   <= '0;
            way_q   <= 3'd0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            way_q   <= way_d;
            pend_q  <= pend_d;
        end
    end

    // Lamp decode from registered state only
    always_comb begin
        luzes_s = '0;
        for (int k = 0; k < N_WAYS; k++) begin
            if ((state_q == VERDE) && (way_q == 3'(k))) begin
                luzes_s[3*k +: 3] = 3'b001;
            end else if ((state_q == AMARELO) && (way_q == 3'(k))) begin
                luzes_s[3*k +: 3] = 3'b010;
            end else begin
                luzes_s[3*k +: 3] = 3'b100;
            end
        end
    end

    assign luzes   = luzes_s;
    assign way_idx = way_q;
    assign walk    = (state_q == PEDESTRE);
    assign pend    = pend_q;

endmodule

// File: tb/tb_semaforo_multi.sv
// Directed bench for semaforo_multi: a 3-way instance for rotation/pedestrian
// sequences and an 8-way instance for the wide rotation.
module tb_semaforo_multi;

    localparam int PH_G = 0;
    localparam int PH_Y = 1;
    localparam int PH_R = 2;
    localparam int PH_P = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        bt  = 1'b0;
    logic        bt8 = 1'b0;
    logic [8:0]  luzes3;
    logic [2:0]  way3;
    logic        walk3, pend3;
    logic [23:0] luzes8;
    logic [2:0]  way8;
    logic        walk8, pend8;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int   cyc;
        logic bt;
        int   ph;
        int   w;
        logic wk;
        logic pd;
        logic cp;
    } vec_t;

    vec_t vecs[$];

    semaforo_multi #(
        .N_WAYS(3), .CNT_W(8), .T_VERDE(5), .T_AMARELO(2), .T_VERMELHO(1),
        .T_PEDESTRE(4), .MIN_VERDE(2)
    ) u3 (
        .clk(clk), .rst(rst), .bt(bt), .luzes(luzes3),
        .way_idx(way3), .walk(walk3), .pend(pend3)
    );

    semaforo_multi #(
        .N_WAYS(8), .CNT_W(8), .T_VERDE(3), .T_AMARELO(3), .T_VERMELHO(3),
        .T_PEDESTRE(4), .MIN_VERDE(1)
    ) u8 (
        .clk(clk), .rst(rst), .bt(bt8), .luzes(luzes8),
        .way_idx(way8), .walk(walk8), .pend(pend8)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] lz(input int n, input int ph, input int w);
        logic [23:0] r;
        r = 24'd0;
        for (int k = 0; k < n; k++) begin
            if (ph == PH_G && k == w)      r[3*k +: 3] = 3'b001;
            else if (ph == PH_Y && k == w) r[3*k +: 3] = 3'b010;
            else                           r[3*k +: 3] = 3'b100;
        end
        return r;
    endfunction

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic add(input int cyc, input logic b, input int ph, input int w,
                       input logic wk, input logic pd, input logic cp);
        vec_t v;
        v.cyc = cyc; v.bt = b; v.ph = ph; v.w = w; v.wk = wk; v.pd = pd; v.cp = cp;
        vecs.push_back(v);
    endtask

    // Hold reset over two edges, release mid-period so the next edge is cycle 0
    task automatic do_reset();
        rst = 1'b0;
        bt  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        // Press sampled at edge 1: shortened green, walk 6-9, way 1 at 10
        add(0, 1'b0, PH_G, 0, 1'b0, 1'b0, 1'b1);
        add(1, 1'b1, PH_G, 0, 1'b0, 1'b0, 1'b1);
        add(2, 1'b0, PH_G, 0, 1'b0, 1'b1, 1'b1);
        add(3, 1'b0, PH_Y, 0, 1'b0, 1'b1, 1'b1);
        add(4, 1'b0, PH_Y, 0, 1'b0, 1'b1, 1'b1);
        add(5, 1'b0, PH_R, 0, 1'b0, 1'b1, 1'b1);
        for (int c = 6; c <= 9; c++) add(c, 1'b0, PH_P, 0, 1'b1, 1'b0, 1'b1);
        add(10, 1'b0, PH_G, 1, 1'b0, 1'b0, 1'b1);
        add(11, 1'b0, PH_G, 1, 1'b0, 1'b0, 1'b1);
        // bt held across cycles 6-12: ignored in walk, relatched after
        add(0, 1'b0, PH_G, 0, 1'b0, 1'b0, 1'b1);
        add(1, 1'b1, PH_G, 0, 1'b0, 1'b0, 1'b1);
        add(2, 1'b0, PH_G, 0, 1'b0, 1'b1, 1'b1);
        add(3, 1'b0, PH_Y, 0, 1'b0, 1'b1, 1'b1);
        add(4, 1'b0, PH_Y, 0, 1'b0, 1'b1, 1'b1);
        add(5, 1'b0, PH_R, 0, 1'b0, 1'b1, 1'b1);
        for (int c = 6; c <= 9; c++) add(c, 1'b1, PH_P, 0, 1'b1, 1'b0, 1'b1);
        add(10, 1'b1, PH_G, 1, 1'b0, 1'b0, 1'b0);
        add(11, 1'b1, PH_G, 1, 1'b0, 1'b1, 1'b1);
        add(12, 1'b1, PH_Y, 1, 1'b0, 1'b1, 1'b1);
        add(13, 1'b0, PH_Y, 1, 1'b0, 1'b1, 1'b1);
        add(14, 1'b0, PH_R, 1, 1'b0, 1'b1, 1'b1);
        for (int c = 15; c <= 18; c++) add(c, 1'b0, PH_P, 1, 1'b1, 1'b0, 1'b1);
        add(19, 1'b0, PH_G, 2, 1'b0, 1'b0, 1'b1);
        // Press during yellow: green untouched, walk 8-11, way 1 at 12
        for (int c = 0; c <= 4; c++) add(c, 1'b0, PH_G, 0, 1'b0, 1'b0, 1'b1);
        add(5, 1'b1, PH_Y, 0, 1'b0, 1'b0, 1'b1);
        add(6, 1'b0, PH_Y, 0, 1'b0, 1'b1, 1'b1);
        add(7, 1'b0, PH_R, 0, 1'b0, 1'b1, 1'b1);
        for (int c = 8; c <= 11; c++) add(c, 1'b0, PH_P, 0, 1'b1, 1'b0, 1'b1);
        add(12, 1'b0, PH_G, 1, 1'b0, 1'b0, 1'b1);

        // Reset state while rst is held low
        #2;
        chk("rst_luzes3", -1, {23'd0, luzes3}, {8'd0, lz(3, PH_G, 0)});
        chk("rst_luzes8", -1, {8'd0, luzes8}, {8'd0, lz(8, PH_G, 0)});
        chk("rst_way", -1, {29'd0, way3}, 32'd0);
        chk("rst_walk_pend", -1, {30'd0, walk3, pend3}, 32'd0);

        // Idle rotation on both instances
        do_reset();
        for (int c = 0; c <= 81; c++) begin
            int ph3, w3, ph8, w8, nonred;
            ph3 = (c % 8 < 5) ? PH_G : ((c % 8 < 7) ? PH_Y : PH_R);
            w3  = (c / 8) % 3;
            ph8 = (c % 9 < 3) ? PH_G : ((c % 9 < 6) ? PH_Y : PH_R);
            w8  = (c / 9) % 8;
            chk("idle3_luzes", c, {23'd0, luzes3}, {8'd0, lz(3, ph3, w3)});
            chk("idle3_way", c, {29'd0, way3}, 32'(w3));
            chk("idle3_walk", c, {31'd0, walk3}, 32'd0);
            chk("idle8_luzes", c, {8'd0, luzes8}, {8'd0, lz(8, ph8, w8)});
            chk("idle8_way", c, {29'd0, way8}, 32'(w8));
            nonred = 0;
            for (int k = 0; k < 8; k++) if (!luzes8[3*k+2]) nonred++;
            chk("idle8_nonred", c, 32'(nonred), (ph8 == PH_R) ? 32'd0 : 32'd1);
            step();
        end

        // Table-driven pedestrian sequences
        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            if (vecs[i].cyc == 0) do_reset();
            tag = $sformatf("vec%0d", i);
            chk({tag, "_luzes"}, vecs[i].cyc, {23'd0, luzes3}, {8'd0, lz(3, vecs[i].ph, vecs[i].w)});
            chk({tag, "_way"}, vecs[i].cyc, {29'd0, way3}, 32'(vecs[i].w));
            chk({tag, "_walk"}, vecs[i].cyc, {31'd0, walk3}, {31'd0, vecs[i].wk});
            if (vecs[i].cp) chk({tag, "_pend"}, vecs[i].cyc, {31'd0, pend3}, {31'd0, vecs[i].pd});
            bt = vecs[i].bt;
            step();
        end
        bt = 1'b0;

        // Reset mid-yellow with a pending request
        do_reset();
        for (int c = 0; c < 3; c++) begin
            bt = (c == 1);
            step();
        end
        bt = 1'b0;
        chk("pre_rst_yellow", 3, {23'd0, luzes3}, {8'd0, lz(3, PH_Y, 0)});
        chk("pre_rst_pend", 3, {31'd0, pend3}, 32'd1);
        rst = 1'b0;
        #1;
        chk("async_rst_luzes", 3, {23'd0, luzes3}, {8'd0, lz(3, PH_G, 0)});
        chk("async_rst_pend", 3, {31'd0, pend3}, 32'd0);
        chk("async_rst_walk", 3, {31'd0, walk3}, 32'd0);
        chk("async_rst_way", 3, {29'd0, way3}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            chk("post_rst_luzes", c, {23'd0, luzes3}, {8'd0, lz(3, (c < 5) ? PH_G : PH_Y, 0)});
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
